// File: rtl/alu_status_monitor.sv
// ALU status consumer: registered flags, sticky flag history and an exception
// request/ack handshake with stall. Define ALU_STATUS_OVF_TRAP_EN to trap on add/sub overflow.
module alu_status_monitor #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 status_valid,
  input  logic [7:0]           ALU_status,
  input  logic [3:0]           ALU_control,
  input  logic [PC_WIDTH-1:0]  pc_in,
  input  logic                 sticky_clear,
  input  logic                 exc_ack,
  output logic [3:0]           flags,
  output logic [7:0]           sticky,
  output logic                 exc_req,
  output logic [2:0]           exc_cause,
  output logic [PC_WIDTH-1:0]  epc,
  output logic [CNT_WIDTH-1:0] exc_count,
  output logic                 stall
);

  typedef enum logic [1:0] {IDLE, PENDING, HOLDOFF} state_t;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

`ifdef ALU_STATUS_OVF_TRAP_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  state_t     state;
  logic       accept;
  logic       ovf_trap;
  logic [2:0] trap_cause;
  logic [7:0] sticky_base;

  always_comb begin
    accept      = (state == IDLE) && status_valid;
    ovf_trap    = OVF_EN && ALU_status[6] &&
                  ((ALU_control == OP_ADD) || (ALU_control == OP_SUB));
    trap_cause  = 3'd0;
    if (ALU_status[3])
      trap_cause = 3'd3;
    else if (ALU_status[2])
      trap_cause = 3'd2;
    else if (ovf_trap)
      trap_cause = 3'd1;
    // A clear coinciding with an accepted status clears first, then ORs.
    sticky_base = sticky_clear ? 8'h00 : sticky;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      flags     <= '0;
      sticky    <= '0;
      exc_cause <= '0;
      epc       <= '0;
      exc_count <= '0;
    end else begin
      if (accept) begin
        flags  <= ALU_status[7:4];
        sticky <= sticky_base | (ALU_status & 8'hFC);
      end else begin
        sticky <= sticky_base;
      end

      case (state)
        IDLE: begin
          if (accept && (trap_cause != 3'd0)) begin
            state     <= PENDING;
            exc_cause <= trap_cause;
            epc       <= pc_in;
          end
        end
        PENDING: begin
          if (exc_ack) begin
            state     <= HOLDOFF;
            exc_cause <= 3'd0;
            if (exc_count != {CNT_WIDTH{1'b1}})
              exc_count <= exc_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        HOLDOFF: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign exc_req = (state == PENDING);
  assign stall   = (state != IDLE);

endmodule

// File: tb/tb_alu_status_monitor.sv
// Scoreboard bench for alu_status_monitor: directed vectors push expected output
// snapshots; a negedge monitor pops and compares them in the cycle they are due.
module tb_alu_status_monitor;

`ifdef ALU_STATUS_OVF_TRAP_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        status_valid;
  logic [7:0]  ALU_status;
  logic [3:0]  ALU_control;
  logic [31:0] pc_in;
  logic        sticky_clear;
  logic        exc_ack;
  logic [3:0]  flags;
  logic [7:0]  sticky;
  logic        exc_req;
  logic [2:0]  exc_cause;
  logic [31:0] epc;
  logic [7:0]  exc_count;
  logic        stall;

  int cyc = 0;
  int total = 0;
  int passed = 0;

  string       name_q[$];
  int          at_q[$];
  logic [56:0] exp_q[$];

  alu_status_monitor #(.PC_WIDTH(32), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .status_valid(status_valid),
    .ALU_status(ALU_status), .ALU_control(ALU_control), .pc_in(pc_in),
    .sticky_clear(sticky_clear), .exc_ack(exc_ack), .flags(flags),
    .sticky(sticky), .exc_req(exc_req), .exc_cause(exc_cause), .epc(epc),
    .exc_count(exc_count), .stall(stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares the due scoreboard entry against the settled outputs.
  always @(negedge clk) begin
    while (at_q.size() > 0 && at_q[0] <= cyc) begin
      string       nm;
      int          at;
      logic [56:0] ex;
      logic [56:0] act;
      nm  = name_q.pop_front();
      at  = at_q.pop_front();
      ex  = exp_q.pop_front();
      act = {flags, sticky, exc_req, exc_cause, epc, exc_count, stall};
      total++;
      if (at != cyc)
        $display("[TB] FAIL %s: entry missed its cycle (due %0d, now %0d)", nm, at, cyc);
      else if (act !== ex)
        $display("[TB] FAIL %s: got %h expected %h", nm, act, ex);
      else
        passed++;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] st, input logic [3:0] ctl,
                               input logic [31:0] pc, input logic clr, input logic ack);
    status_valid = v;
    ALU_status   = st;
    ALU_control  = ctl;
    pc_in        = pc;
    sticky_clear = clr;
    exc_ack      = ack;
    cycle();
    status_valid = 1'b0;
    ALU_status   = 8'h00;
    ALU_control  = 4'h0;
    pc_in        = 32'h0;
    sticky_clear = 1'b0;
    exc_ack      = 1'b0;
  endtask

  // Pushes the expected outputs for the current cycle onto the scoreboard.
  task automatic checkOutput(input string nm, input logic [3:0] f, input logic [7:0] s,
                             input logic r, input logic [2:0] c, input logic [31:0] e,
                             input logic [7:0] n, input logic st);
    name_q.push_back(nm);
    at_q.push_back(cyc);
    exp_q.push_back({f, s, r, c, e, n, st});
  endtask

  initial begin
    logic [7:0]  ec;
    logic [31:0] ee;
    logic [7:0]  sat;
    reset = 1'b1;
    status_valid = 1'b0; ALU_status = 8'h00; ALU_control = 4'h0;
    pc_in = 32'h0; sticky_clear = 1'b0; exc_ack = 1'b0;
    cycle();
    cycle();
    checkOutput("reset", 4'h0, 8'h00, 1'b0, 3'd0, 32'h0, 8'h00, 1'b0);
    reset = 1'b0;

    applyStimulus(1'b1, 8'h80, 4'b0000, 32'h10, 1'b0, 1'b0);
    checkOutput("zero_and", 4'b1000, 8'h80, 1'b0, 3'd0, 32'h0, 8'h00, 1'b0);

    applyStimulus(1'b1, 8'h40, 4'b0010, 32'h40, 1'b0, 1'b0);
    if (OVF) begin
      checkOutput("ovf_add_trap", 4'b0100, 8'hC0, 1'b1, 3'd1, 32'h40, 8'h00, 1'b1);
      applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("ovf_hold1", 4'b0100, 8'hC0, 1'b1, 3'd1, 32'h40, 8'h00, 1'b1);
      applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("ovf_hold2", 4'b0100, 8'hC0, 1'b1, 3'd1, 32'h40, 8'h00, 1'b1);
      applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 1'b1);
      checkOutput("ovf_ack_holdoff", 4'b0100, 8'hC0, 1'b0, 3'd0, 32'h40, 8'h01, 1'b1);
      applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("ovf_back_idle", 4'b0100, 8'hC0, 1'b0, 3'd0, 32'h40, 8'h01, 1'b0);
      ec = 8'h01;
      ee = 32'h40;
    end else begin
      checkOutput("ovf_add_no_trap", 4'b0100, 8'hC0, 1'b0, 3'd0, 32'h0, 8'h00, 1'b0);
      applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 1'b1);
      checkOutput("ack_idle_ignored", 4'b0100, 8'hC0, 1'b0, 3'd0, 32'h0, 8'h00, 1'b0);
      ec = 8'h00;
      ee = 32'h0;
    end

    applyStimulus(1'b1, 8'h10, 4'b0000, 32'h50, 1'b1, 1'b0);
    checkOutput("clear_with_accept", 4'b0001, 8'h10, 1'b0, 3'd0, ee, ec, 1'b0);

    applyStimulus(1'b1, 8'h0C, 4'b0110, 32'h100, 1'b0, 1'b0);
    checkOutput("inv_addr_prio", 4'b0000, 8'h1C, 1'b1, 3'd3, 32'h100, ec, 1'b1);
    applyStimulus(1'b1, 8'h8C, 4'b0110, 32'h104, 1'b0, 1'b0);
    checkOutput("valid_in_pending", 4'b0000, 8'h1C, 1'b1, 3'd3, 32'h100, ec, 1'b1);
    applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 1'b1);
    ec = ec + 8'd1;
    checkOutput("ack_min_pending", 4'b0000, 8'h1C, 1'b0, 3'd0, 32'h100, ec, 1'b1);
    applyStimulus(1'b1, 8'h80, 4'b0000, 32'h108, 1'b0, 1'b0);
    checkOutput("valid_in_holdoff", 4'b0000, 8'h1C, 1'b0, 3'd0, 32'h100, ec, 1'b0);

    applyStimulus(1'b1, 8'h44, 4'b0010, 32'h200, 1'b0, 1'b0);
    checkOutput("div_zero_over_ovf", 4'b0100, 8'h5C, 1'b1, 3'd2, 32'h200, ec, 1'b1);
    applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("clear_in_pending", 4'b0100, 8'h00, 1'b1, 3'd2, 32'h200, ec, 1'b1);
    reset = 1'b1;
    cycle();
    checkOutput("reset_in_pending", 4'h0, 8'h00, 1'b0, 3'd0, 32'h0, 8'h00, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("ack_after_reset", 4'h0, 8'h00, 1'b0, 3'd0, 32'h0, 8'h00, 1'b0);

    applyStimulus(1'b1, 8'h40, 4'b0000, 32'h10, 1'b0, 1'b0);
    checkOutput("ovf_and_no_trap", 4'b0100, 8'h40, 1'b0, 3'd0, 32'h0, 8'h00, 1'b0);

    for (int i = 1; i <= 257; i++) begin
      applyStimulus(1'b1, 8'h04, 4'b0000, 32'h300, 1'b0, 1'b0);
      if (i == 1)
        checkOutput("sat_trap", 4'b0000, 8'h44, 1'b1, 3'd2, 32'h300, 8'h00, 1'b1);
      applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 1'b1);
      sat = (i > 255) ? 8'hFF : 8'(i);
      if (i == 1 || i == 254 || i == 255 || i == 256 || i == 257)
        checkOutput($sformatf("sat_count_%0d", i), 4'b0000, 8'h44, 1'b0, 3'd0, 32'h300, sat, 1'b1);
      applyStimulus(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 1'b0);
    end
    checkOutput("sat_final_idle", 4'b0000, 8'h44, 1'b0, 3'd0, 32'h300, 8'hFF, 1'b0);

    cycle();
    cycle();
    while (name_q.size() > 0) begin
      $display("[TB] FAIL %s: never compared", name_q.pop_front());
      void'(at_q.pop_front());
      void'(exp_q.pop_front());
      total++;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
